// File: rtl/bcrypt_axi_pkg.sv
// Shared types and constants for the Bcrypt AXI4 burst slave front end.
// Optional WRAP support is controlled by the BCRYPT_AXI_WRAP_EN macro.
package bcrypt_axi_pkg;

    localparam int unsigned DATA_W   = 32;
    localparam int unsigned STRB_W   = DATA_W / 8;
    localparam logic [2:0]  AXI_SIZE = 3'b010;

    typedef enum logic [1:0] {
        BURST_FIXED = 2'b00,
        BURST_INCR  = 2'b01,
        BURST_WRAP  = 2'b10,
        BURST_RSVD  = 2'b11
    } burst_t;

    typedef enum logic [1:0] {
        RESP_OKAY   = 2'b00,
        RESP_EXOKAY = 2'b01,
        RESP_SLVERR = 2'b10,
        RESP_DECERR = 2'b11
    } resp_t;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_WDATA,
        ST_WRESP,
        ST_RDATA
    } state_t;

    function automatic logic wrap_len_ok(input logic [7:0] len);
        return (len == 8'd1) || (len == 8'd3) || (len == 8'd7) || (len == 8'd15);
    endfunction

endpackage

// File: rtl/bcrypt_axi_addr_gen.sv
// Next-beat address and per-beat legality for the single active burst.
// WRAP bursts are legal only when BCRYPT_AXI_WRAP_EN is defined.
module bcrypt_axi_addr_gen
    import bcrypt_axi_pkg::*;
#(
    parameter int unsigned ADDR_W    = 12,
    parameter int unsigned MEM_DEPTH = 64
) (
    input  logic [ADDR_W-1:0] i_addr,
    input  logic [7:0]        i_len,
    input  burst_t            i_burst,
    output logic [ADDR_W-1:0] o_next_addr,
    output logic              o_in_range,
    output logic              o_burst_err
);

    localparam logic [ADDR_W:0] LIMIT = (ADDR_W + 1)'(MEM_DEPTH * 4);

    logic [ADDR_W-1:0] w_step;
    logic [ADDR_W-1:0] w_mask;

    assign w_step = i_addr + ADDR_W'(4);
    // For the legal lengths 1/3/7/15 this is (len+1)*4-1; other lengths are flagged as errors.
    assign w_mask = ADDR_W'({i_len, 2'b11});

    always_comb begin
        o_next_addr = i_addr;
        unique case (i_burst)
            BURST_INCR: o_next_addr = w_step;
            BURST_WRAP: o_next_addr = (i_addr & ~w_mask) | (w_step & w_mask);
            default:    o_next_addr = i_addr;
        endcase
    end

    assign o_in_range = ({1'b0, i_addr} < LIMIT);

`ifdef BCRYPT_AXI_WRAP_EN
    assign o_burst_err = (i_burst == BURST_RSVD) ||
                         ((i_burst == BURST_WRAP) && !wrap_len_ok(i_len));
`else
    assign o_burst_err = (i_burst == BURST_RSVD) || (i_burst == BURST_WRAP);
`endif

endmodule

// File: rtl/bcrypt_axi_burst_slave.sv
// AXI4 burst slave with a 32-bit word buffer feeding the Bcrypt parameter RAM.
// One burst at a time; WRAP support requires BCRYPT_AXI_WRAP_EN.
module bcrypt_axi_burst_slave
    import bcrypt_axi_pkg::*;
#(
    parameter int unsigned C_S_AXI_ADDR_WIDTH = 12,
    parameter int unsigned MEM_DEPTH          = 64
) (
    input  logic                          ACLK,
    input  logic                          ARESET,
    input  logic [C_S_AXI_ADDR_WIDTH-1:0] S_AXI_AWADDR,
    input  logic [7:0]                    S_AXI_AWLEN,
    input  logic [1:0]                    S_AXI_AWBURST,
    input  logic                          S_AXI_AWVALID,
    output logic                          S_AXI_AWREADY,
    input  logic [31:0]                   S_AXI_WDATA,
    input  logic [3:0]                    S_AXI_WSTRB,
    input  logic                          S_AXI_WLAST,
    input  logic                          S_AXI_WVALID,
    output logic                          S_AXI_WREADY,
    output logic [1:0]                    S_AXI_BRESP,
    output logic                          S_AXI_BVALID,
    input  logic                          S_AXI_BREADY,
    input  logic [C_S_AXI_ADDR_WIDTH-1:0] S_AXI_ARADDR,
    input  logic [7:0]                    S_AXI_ARLEN,
    input  logic [1:0]                    S_AXI_ARBURST,
    input  logic                          S_AXI_ARVALID,
    output logic                          S_AXI_ARREADY,
    output logic [31:0]                   S_AXI_RDATA,
    output logic [1:0]                    S_AXI_RRESP,
    output logic                          S_AXI_RLAST,
    output logic                          S_AXI_RVALID,
    input  logic                          S_AXI_RREADY
);

    localparam int unsigned AW    = C_S_AXI_ADDR_WIDTH;
    localparam int unsigned IDX_W = (MEM_DEPTH > 1) ? $clog2(MEM_DEPTH) : 1;

    state_t            r_state;
    state_t            w_state_nxt;
    logic [AW-1:0]     r_addr;
    logic [7:0]        r_len;
    burst_t            r_burst;
    logic [8:0]        r_beat;
    logic              r_err;
    logic              r_wr_prio;
    logic [DATA_W-1:0] r_mem [0:MEM_DEPTH-1];

    logic [AW-1:0]     w_next_addr;
    logic              w_in_range;
    logic              w_burst_err;
    logic              w_beat_ok;
    logic [IDX_W-1:0]  w_word;
    logic              w_grant_w;
    logic              w_grant_r;
    logic              w_awready;
    logic              w_arready;
    logic              w_wready;
    logic              w_bvalid;
    logic              w_rvalid;
    logic              w_last_beat;
    logic              w_w_hs;
    logic              w_r_hs;

    bcrypt_axi_addr_gen #(
        .ADDR_W    (AW),
        .MEM_DEPTH (MEM_DEPTH)
    ) u_addr_gen (
        .i_addr      (r_addr),
        .i_len       (r_len),
        .i_burst     (r_burst),
        .o_next_addr (w_next_addr),
        .o_in_range  (w_in_range),
        .o_burst_err (w_burst_err)
    );

    assign w_beat_ok   = w_in_range && !w_burst_err;
    assign w_word      = r_addr[2 +: IDX_W];
    assign w_last_beat = (r_beat == {1'b0, r_len});
    assign w_w_hs      = w_wready && S_AXI_WVALID;
    assign w_r_hs      = w_rvalid && S_AXI_RREADY;

    // Everything is gated by ARESET so outputs read 0 even before the first reset edge.
    always_comb begin
        w_state_nxt = r_state;
        w_grant_w   = 1'b0;
        w_grant_r   = 1'b0;
        w_awready   = 1'b0;
        w_arready   = 1'b0;
        w_wready    = 1'b0;
        w_bvalid    = 1'b0;
        w_rvalid    = 1'b0;
        if (!ARESET) begin
            unique case (r_state)
                ST_IDLE: begin
                    w_grant_w = S_AXI_AWVALID && (!S_AXI_ARVALID || r_wr_prio);
                    w_grant_r = S_AXI_ARVALID && !w_grant_w;
                    w_awready = w_grant_w;
                    w_arready = w_grant_r;
                    if (w_grant_w) begin
                        w_state_nxt = ST_WDATA;
                    end else if (w_grant_r) begin
                        w_state_nxt = ST_RDATA;
                    end
                end
                ST_WDATA: begin
                    w_wready = 1'b1;
                    if (S_AXI_WVALID && S_AXI_WLAST) begin
                        w_state_nxt = ST_WRESP;
                    end
                end
                ST_WRESP: begin
                    w_bvalid = 1'b1;
                    if (S_AXI_BREADY) begin
                        w_state_nxt = ST_IDLE;
                    end
                end
                ST_RDATA: begin
                    w_rvalid = 1'b1;
                    if (S_AXI_RREADY && w_last_beat) begin
                        w_state_nxt = ST_IDLE;
                    end
                end
                default: w_state_nxt = ST_IDLE;
            endcase
        end
    end

    always_ff @(posedge ACLK) begin
        if (ARESET) begin
            r_state   <= ST_IDLE;
            r_addr    <= '0;
            r_len     <= '0;
            r_burst   <= BURST_INCR;
            r_beat    <= '0;
            r_err     <= 1'b0;
            r_wr_prio <= 1'b1;
        end else begin
            r_state <= w_state_nxt;
            if (w_grant_w || w_grant_r) begin
                // Priority only flips when both requests competed.
                if (S_AXI_AWVALID && S_AXI_ARVALID) begin
                    r_wr_prio <= w_grant_r;
                end
                r_beat <= '0;
                r_err  <= 1'b0;
                if (w_grant_w) begin
                    r_addr  <= S_AXI_AWADDR;
                    r_len   <= S_AXI_AWLEN;
                    r_burst <= burst_t'(S_AXI_AWBURST);
                end else begin
                    r_addr  <= S_AXI_ARADDR;
                    r_len   <= S_AXI_ARLEN;
                    r_burst <= burst_t'(S_AXI_ARBURST);
                end
            end
            if (w_w_hs) begin
                r_addr <= w_next_addr;
                r_beat <= r_beat + 9'd1;
                if (!w_beat_ok || (S_AXI_WLAST && !w_last_beat)) begin
                    r_err <= 1'b1;
                end
            end
            if (w_r_hs) begin
                r_addr <= w_next_addr;
                r_beat <= r_beat + 9'd1;
            end
        end
    end

    // Buffer is deliberately not reset; words written before a reset survive it.
    always_ff @(posedge ACLK) begin
        if (w_w_hs && w_beat_ok) begin
            for (int unsigned b = 0; b < STRB_W; b++) begin
                if (S_AXI_WSTRB[b]) begin
                    r_mem[w_word][8*b +: 8] <= S_AXI_WDATA[8*b +: 8];
                end
            end
        end
    end

    assign S_AXI_AWREADY = w_awready;
    assign S_AXI_ARREADY = w_arready;
    assign S_AXI_WREADY  = w_wready;
    assign S_AXI_BVALID  = w_bvalid;
    assign S_AXI_BRESP   = (w_bvalid && r_err) ? RESP_SLVERR : RESP_OKAY;
    assign S_AXI_RVALID  = w_rvalid;
    assign S_AXI_RLAST   = w_rvalid && w_last_beat;
    assign S_AXI_RRESP   = (w_rvalid && !w_beat_ok) ? RESP_SLVERR : RESP_OKAY;
    assign S_AXI_RDATA   = (w_rvalid && w_beat_ok) ? r_mem[w_word] : '0;

endmodule
